setpoint_ramp_scheduler: RTL
============================

Name: setpoint_ramp_scheduler

Overview:
Slew-limited setpoint controller between the MCU parallel bus and the two-phase DC-DC PWM/control datapath. It captures MCU bus writes into the clk domain and decodes them into three target registers. A single shared ramp engine, scheduled round-robin, moves each output setpoint toward its target by at most STEP per service tick. This gives soft-start and glitch-free setpoint changes for phase A, phase B and the current limit.

Parameters:
STEP, 16'd8, maximum change of one output per service
TICK_DIV, 1000, clk cycles per service tick (>=2)
DEF0, 16'd10000, reset value of target0/out0
DEF1, 16'd0, reset value of target1/out1
DEF2, 16'd0, reset value of target2/out2

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
bus_addr  in  12  MCU address; [11:8] selects the channel, [7:0] is the mode field
bus_wr  in  1  MCU write strobe, asynchronous to clk, active-high
bus_data  in  16  MCU write data, held stable while bus_wr is high
enable  in  1  1 = ramp engine runs; 0 = outputs frozen
out0  out  16  ramped setpoint, channel 0 (phase A)
out1  out  16  ramped setpoint, channel 1 (phase B)
out2  out  16  ramped setpoint, channel 2 (current limit)
busy_vec  out  3  bit k = (out_k != target_k)
wr_ack  out  1  one-cycle pulse: valid write accepted
err_addr  out  1  one-cycle pulse: write to an undecoded channel

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: target_k = out_k = DEFk; busy_vec = 0; wr_ack = err_addr = 0; tick counter = 0; round-robin pointer = 0. Reset mid-ramp snaps outputs to DEFk.
- Sync: bus_wr, bus_addr and bus_data pass through 2-FF synchronisers (s1, s2), followed by a delayed copy wr_d. s1, s2 and wr_d reset to 1, so a strobe already high at reset release is ignored.
- Write detect: s2 & ~wr_d. Let E0 be the edge at which s1 first samples 1. Detect is true in the cycle after E1. At E2 the target is written and wr_ack/err_addr asserts for one cycle.
- Decode on the synchronised addr[11:8]:
  - 0/1/2: write target_k.
  - Any other value: err_addr pulse only; no state change.
  - If addr[7:0] == 8'hFF (direct load), out_k is also written at E2, bypassing the ramp.
- Tick: counter runs 0..TICK_DIV-1 while enable=1 and wraps. tick = 1 in the cycle the count equals TICK_DIV-1. enable=0 clears the counter and suppresses ticks; targets remain writable.
- Scheduler, per tick:
  - Search channels starting from ptr, then ptr+1, ptr+2 (mod 3), for the first k with out_k != target_k.
  - If found, service k and set ptr = (k+1) mod 3.
  - If none is found, no action and ptr is unchanged.
  - Result: with n channels busy, each busy channel is serviced once every n ticks.
- Service arithmetic (unsigned 16-bit, no wrap):
  - If |target-out| <= STEP: out = target.
  - Else if target > out: out += STEP.
  - Else: out -= STEP.
  - Update is visible the cycle after the tick.
- Simultaneous write and service on the same channel in one cycle: the service uses the old target; the new target applies from the next service. A direct load takes priority over the service result.
- A new target written mid-ramp reverses direction at the next service if needed; no other state is cleared.
- busy_vec is combinational from the registers.

Test Plan:
- Reset with rst=1 for 2 cycles -> out0=10000, out1=0, out2=0, busy_vec=000; bus_wr held high across release produces no wr_ack.
- TICK_DIV=4, enable=1; write addr 12'h100, data 40 -> wr_ack 1 cycle at E2+1; out1 steps 8,16,24,32,40 on successive ticks (4 cycles apart); busy_vec[1] falls after 40.
- Write ch1=24 then ch2=16 back-to-back -> services alternate ch1,ch2,ch1,ch2,ch1; out1 8/16/24, out2 8/16; ptr fairness confirmed.
- Write addr 12'h000, data 9995 -> next tick out0=9995 (clamp, not 9992). Then write addr 12'h2FF, data 500 -> out2=500 at E2 with no ramp and busy_vec[2]=0.
- Write addr 12'h300 -> err_addr pulse, no wr_ack, all targets/outputs unchanged. With enable=0 during an active ramp: outputs frozen, target still updated; ramp resumes after enable=1.
- Assert rst mid-ramp (out1=16, target1=40) -> next cycle out1=0, target1=0, busy_vec=000.

Source files
------------

// File: rtl/setpoint_ramp_scheduler.sv
// Slew-limited setpoint controller: MCU bus writes set three targets, and a shared
// round-robin ramp engine moves each output toward its target by at most STEP per tick.
module setpoint_ramp_scheduler #(
  parameter logic [15:0] STEP     = 16'd8,
  parameter int unsigned TICK_DIV = 1000,
  parameter logic [15:0] DEF0     = 16'd10000,
  parameter logic [15:0] DEF1     = 16'd0,
  parameter logic [15:0] DEF2     = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bus_addr,
  input  logic        bus_wr,
  input  logic [15:0] bus_data,
  input  logic        enable,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [2:0]  busy_vec,
  output logic        wr_ack,
  output logic        err_addr
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic        wr_s1, wr_s2, wr_d;
  logic [11:0] addr_s1, addr_s2;
  logic [15:0] data_s1, data_s2;
  logic [CW-1:0] cnt;
  logic [1:0]  ptr;
  logic [15:0] tgt  [3];
  logic [15:0] outr [3];

  logic        wr_det, wr_valid, wr_direct;
  logic [1:0]  wr_ch;
  logic        tick;
  logic [1:0]  cand [3];
  logic        found;
  logic [1:0]  sel;
  logic [15:0] tgt_s, out_s, diff, svc;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign wr_det    = wr_s2 & ~wr_d;
  assign wr_valid  = (addr_s2[11:8] < 4'd3);
  assign wr_ch     = addr_s2[9:8];
  assign wr_direct = (addr_s2[7:0] == 8'hFF);
  assign tick      = enable && (cnt == CW'(TICK_DIV - 1));

  assign busy_vec = {outr[2] != tgt[2], outr[1] != tgt[1], outr[0] != tgt[0]};
  assign out0 = outr[0];
  assign out1 = outr[1];
  assign out2 = outr[2];

  // First busy channel at or after ptr, in rotating order.
  always_comb begin
    found   = 1'b0;
    sel     = 2'd0;
    cand[0] = ptr;
    cand[1] = inc3(ptr);
    cand[2] = inc3(inc3(ptr));
    for (int unsigned i = 0; i < 3; i++) begin
      if (!found && busy_vec[cand[i]]) begin
        found = 1'b1;
        sel   = cand[i];
      end
    end
  end

  always_comb begin
    tgt_s = tgt[sel];
    out_s = outr[sel];
    diff  = (tgt_s >= out_s) ? (tgt_s - out_s) : (out_s - tgt_s);
    if (diff <= STEP)       svc = tgt_s;
    else if (tgt_s > out_s) svc = out_s + STEP;
    else                    svc = out_s - STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_s1    <= 1'b1;
      wr_s2    <= 1'b1;
      wr_d     <= 1'b1;
      addr_s1  <= '0;
      addr_s2  <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
      cnt      <= '0;
      ptr      <= 2'd0;
      wr_ack   <= 1'b0;
      err_addr <= 1'b0;
      tgt[0]   <= DEF0;
      tgt[1]   <= DEF1;
      tgt[2]   <= DEF2;
      outr[0]  <= DEF0;
      outr[1]  <= DEF1;
      outr[2]  <= DEF2;
    end else begin
      wr_s1   <= bus_wr;
      wr_s2   <= wr_s1;
      wr_d    <= wr_s2;
      addr_s1 <= bus_addr;
      addr_s2 <= addr_s1;
      data_s1 <= bus_data;
      data_s2 <= data_s1;

      wr_ack   <= wr_det && wr_valid;
      err_addr <= wr_det && !wr_valid;

      if (!enable || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);

      if (tick && found) begin
        outr[sel] <= svc;
        ptr       <= inc3(sel);
      end

      // Placed after the service so a direct load overrides it; the service already used the old target.
      if (wr_det && wr_valid) begin
        tgt[wr_ch] <= data_s2;
        if (wr_direct) outr[wr_ch] <= data_s2;
      end
    end
  end

endmodule
